// File: rtl/bcd_countdown.sv
// -----------------------------------------------------------------------------
// bcd_countdown
//   Multi-digit BCD countdown timer. It counts down one second per sec_tick
//   while running, and pulses expired when it reaches zero.
//   States: IDLE -> (load) ARMED -> (start) RUN <-> (pause/start) PAUSE
//           RUN -> (count hits zero) EXPIRED
//   Control priority: abort > load > start/pause > sec_tick.
//
// Parameters
//   DIGITS : number of BCD digits (2..6)
//   MMSS   : 1 -> digit 1 is tens-of-seconds (0..5), digits 2+ are minutes
//            0 -> every digit is plain decimal 0..9
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   sec_tick     in   one-cycle pulse per elapsed second
//   init_time    in   [4*DIGITS] BCD load value, digit 0 in the low nibble
//   load         in   capture init_time (clamped per digit), go ARMED
//   start        in   begin/resume counting
//   pause        in   freeze the count
//   abort        in   return to IDLE with count 0
//   penalty      in   (BCD_COUNTDOWN_PENALTY_EN only) add penalty_sec to pending
//   penalty_sec  in   (BCD_COUNTDOWN_PENALTY_EN only) [8] seconds of penalty
//   count        out  [4*DIGITS] current BCD value
//   running      out  high while in RUN
//   expired      out  one-cycle pulse when the count reaches zero
//   at_zero      out  high while count is zero
//
// Optional feature: define BCD_COUNTDOWN_PENALTY_EN to add the penalty ports
// and an 8-bit pending-penalty register that drains one second per clock
// while in RUN or PAUSE.
// -----------------------------------------------------------------------------
module bcd_countdown #(
   parameter int DIGITS = 3,
   parameter int MMSS   = 0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                sec_tick,
   input  logic [4*DIGITS-1:0] init_time,
   input  logic                load,
   input  logic                start,
   input  logic                pause,
   input  logic                abort,
`ifdef BCD_COUNTDOWN_PENALTY_EN
   input  logic                penalty,
   input  logic [7:0]          penalty_sec,
`endif
   output logic [4*DIGITS-1:0] count,
   output logic                running,
   output logic                expired,
   output logic                at_zero
);

   localparam int W = 4 * DIGITS;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ARMED   = 3'd1,
      ST_RUN     = 3'd2,
      ST_PAUSE   = 3'd3,
      ST_EXPIRED = 3'd4
   } state_t;

   state_t state;

   // Largest legal value of digit i (tens-of-seconds digit is 0..5 in MMSS).
   function automatic logic [3:0] digit_max(input int i);
      return (MMSS != 0 && i == 1) ? 4'd5 : 4'd9;
   endfunction

   // Saturate every nibble to its digit's maximum.
   function automatic logic [W-1:0] clamp_time(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic [3:0]   nib;
      r = v;
      for (int i = 0; i < DIGITS; i++) begin
         nib = v[4*i +: 4];
         if (nib > digit_max(i)) nib = digit_max(i);
         r[4*i +: 4] = nib;
      end
      return r;
   endfunction

   // Subtract one second with a borrow chain; zero stays at zero.
   function automatic logic [W-1:0] dec_sec(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic [3:0]   nib;
      logic         borrow;
      r      = v;
      borrow = (v != '0);
      for (int i = 0; i < DIGITS; i++) begin
         nib = v[4*i +: 4];
         if (borrow) begin
            if (nib == 4'd0) begin
               nib = digit_max(i);
            end else begin
               nib    = nib - 4'd1;
               borrow = 1'b0;
            end
         end
         r[4*i +: 4] = nib;
      end
      return r;
   endfunction

   logic         tick_take;
   logic         drain;
   logic         stay_run;
   logic [W-1:0] cnt_dec;

`ifdef BCD_COUNTDOWN_PENALTY_EN
   logic [7:0] pending;
   logic [8:0] pend_sum;
   logic [7:0] pend_nxt;
`endif

   always_comb begin
      // A pause in the same cycle as a tick wins; the tick is dropped.
      tick_take = (state == ST_RUN) && !pause && sec_tick;
      stay_run  = ((state == ST_RUN) && !pause) || ((state == ST_PAUSE) && start);
`ifdef BCD_COUNTDOWN_PENALTY_EN
      drain     = (pending != 8'd0);
      pend_sum  = {1'b0, pending - {7'd0, drain}}
                + (penalty ? {1'b0, penalty_sec} : 9'd0);
      pend_nxt  = pend_sum[8] ? 8'hFF : pend_sum[7:0];
`else
      drain     = 1'b0;
`endif
      // Drain and tick stack so a tick during a drain cycle is not lost.
      cnt_dec = count;
      if (drain)     cnt_dec = dec_sec(cnt_dec);
      if (tick_take) cnt_dec = dec_sec(cnt_dec);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         count   <= '0;
         expired <= 1'b0;
`ifdef BCD_COUNTDOWN_PENALTY_EN
         pending <= 8'd0;
`endif
      end else begin
         expired <= 1'b0;
         if (abort) begin
            state <= ST_IDLE;
            count <= '0;
`ifdef BCD_COUNTDOWN_PENALTY_EN
            pending <= 8'd0;
`endif
         end else if (load) begin
            state <= ST_ARMED;
            count <= clamp_time(init_time);
`ifdef BCD_COUNTDOWN_PENALTY_EN
            pending <= 8'd0;
`endif
         end else begin
            case (state)
               ST_ARMED: begin
                  if (start) begin
                     if (count == '0) begin
                        state   <= ST_EXPIRED;
                        expired <= 1'b1;
                     end else begin
                        state <= ST_RUN;
                     end
                  end
               end
               ST_RUN, ST_PAUSE: begin
                  // Count is always nonzero here, so reaching zero means a
                  // decrement just happened.
                  if (cnt_dec == '0) begin
                     state   <= ST_EXPIRED;
                     count   <= '0;
                     expired <= 1'b1;
`ifdef BCD_COUNTDOWN_PENALTY_EN
                     pending <= 8'd0;
`endif
                  end else begin
                     state <= stay_run ? ST_RUN : ST_PAUSE;
                     count <= cnt_dec;
`ifdef BCD_COUNTDOWN_PENALTY_EN
                     pending <= pend_nxt;
`endif
                  end
               end
               default: ;  // IDLE and EXPIRED hold
            endcase
         end
      end
   end

   assign running = (state == ST_RUN);
   assign at_zero = (count == '0);

endmodule

// File: doc/bcd_countdown.md
BCD_COUNTDOWN -- requirements
Module: bcd_countdown

Interface
REQ-001 SHALL provide parameter DIGITS, default 3: number of BCD digits, legal range 2..6.
REQ-002 SHALL provide parameter MMSS, default 0: when 1, digit 1 is tens-of-seconds (0..5) and digits 2 and up are minutes; when 0, all digits are decimal 0..9.
REQ-003 SHALL have port clk  in  1  system clock; all state changes occur on the rising edge.
REQ-004 SHALL have port reset  in  1  reset, asynchronous and active-high.
REQ-005 SHALL have port sec_tick  in  1  one-cycle pulse marking one elapsed second.
REQ-006 SHALL have port init_time  in  4*DIGITS  initial BCD value; digit 0 is the least significant nibble.
REQ-007 SHALL have port load  in  1  pulse: capture init_time.
REQ-008 SHALL have port start  in  1  pulse: begin or resume counting.
REQ-009 SHALL have port pause  in  1  pulse: freeze the count.
REQ-010 SHALL have port abort  in  1  pulse: return to idle.
REQ-011 SHALL have port count  out  4*DIGITS  current BCD value.
REQ-012 SHALL have port running  out  1  high while in RUN.
REQ-013 SHALL have port expired  out  1  one-cycle pulse on reaching zero.
REQ-014 SHALL have port at_zero  out  1  high while count equals zero.

Function
REQ-015 SHALL implement the states IDLE, ARMED, RUN, PAUSE and EXPIRED.
REQ-016 SHALL resolve simultaneous controls with priority abort > load > start/pause > sec_tick.
REQ-017 SHALL, on abort in any state, go to IDLE and clear count to 0.
REQ-018 SHALL, on load in any state, go to ARMED with count set to init_time clamped per digit: values above 9 become 9; in MMSS mode, digit 1 above 5 becomes 5.
REQ-019 SHALL leave state and count unchanged on start or pause received in IDLE.
REQ-020 SHALL go ARMED->RUN and PAUSE->RUN on start; start in RUN or EXPIRED SHALL have no effect.
REQ-021 SHALL go RUN->PAUSE on pause; a sec_tick in the same cycle SHALL be discarded.
REQ-022 SHALL ignore sec_tick in IDLE, ARMED, PAUSE and EXPIRED.
REQ-023 SHALL decrement count by one second on each sec_tick in RUN, one clock of latency.
REQ-024 SHALL decrement with a borrow chain: a digit at 0 wraps to 9, or to 5 for digit 1 in MMSS mode, and borrows from the next digit.
REQ-025 SHALL, when a decrement produces zero, enter EXPIRED in the same edge and assert expired for exactly that following cycle.
REQ-026 SHALL, on start in ARMED with count equal to 0, go directly to EXPIRED and pulse expired once.
REQ-027 SHALL never decrement below zero; count SHALL hold at 0 in EXPIRED until load or abort.
REQ-028 SHALL produce running and at_zero as registered or decoded from registered state only, with no combinational input-to-output path.

Reset
REQ-029 SHALL, while reset is high, force state IDLE, count 0, running 0, expired 0, at_zero 1, and any pending penalty 0.
REQ-030 SHALL, on reset asserted mid-count, discard the count; after release the block SHALL require load before start has effect.

Configuration
REQ-031 SHALL, when macro BCD_COUNTDOWN_PENALTY_EN is defined, add ports penalty (in, 1) and penalty_sec (in, 8).
REQ-032 SHALL, with the macro defined, add penalty_sec to an 8-bit pending register saturating at 255 on each penalty pulse in RUN or PAUSE; penalty SHALL be ignored in other states.
REQ-033 SHALL, with the macro defined, drain pending by one second per clock cycle in RUN or PAUSE, using the same borrow chain.
REQ-034 SHALL, with the macro defined, let a sec_tick coinciding with a drain cycle decrement by one second in addition to the drain, so the tick is not lost; reaching zero SHALL expire as in REQ-025 and clear pending.
REQ-035 SHALL, with the macro defined, clear pending on load or abort.
REQ-036 SHALL, without the macro, have no penalty ports and no pending register, with behaviour identical to REQ-001..REQ-030.

Verification
REQ-037 SHALL cover: DIGITS=3, MMSS=0, load 0x120, start, 1 tick -> count 0x119; 10 more ticks -> 0x109; 10 more -> 0x099.
REQ-038 SHALL cover: MMSS=1, load 0x100, start, 1 tick -> count 0x059; load 0x07F -> count clamped to 0x059.
REQ-039 SHALL cover: load 0x002, start, 2 ticks -> expired high exactly 1 cycle after the 2nd tick, at_zero=1, running=0; a 3rd tick leaves count 0x000.
REQ-040 SHALL cover: in RUN, pause and sec_tick in the same cycle -> count unchanged, state PAUSE; start -> RUN; abort together with load -> IDLE, count 0x000.
REQ-041 SHALL cover, with BCD_COUNTDOWN_PENALTY_EN defined: count 0x030 in RUN, penalty with penalty_sec=15 -> count 0x015 after 15 cycles; a penalty of 40 -> expired pulse once, count 0x000.
REQ-042 SHALL cover: reset asserted mid-RUN at count 0x057 -> outputs go to reset values with no clock edge required; start after release with no load -> state remains IDLE.
